// File: rtl/fetch_sched_pkg.sv
// Shared types for the vertex-fetch scheduler: FSM states, response kinds
// and the tagged response record handed to the requesters.
package fetch_sched_pkg;

    // Widest requester id (NUM_REQ up to 16); narrower configs zero-extend.
    localparam int ID_W_MAX = 4;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ISSUE       = 3'd1,
        ST_DRAIN_POS   = 3'd2,
        ST_DRAIN_NEIGH = 3'd3,
        ST_END         = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        KIND_POS   = 2'd0,
        KIND_NEIGH = 2'd1,
        KIND_END   = 2'd2
    } resp_kind_t;

    typedef struct packed {
        logic [31:0]         data;
        resp_kind_t          kind;
        logic [ID_W_MAX-1:0] id;
    } resp_t;

endpackage

// File: rtl/fetch_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after the
// pointer, wrapping modulo N. The pointer itself lives in the caller.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] w_cand;

    // Scan N candidates starting at the pointer; the first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % N);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/fetch_scheduler.sv
// Shares one vertex-fetch unit between NUM_REQ requesters. One fetch in
// flight: issue the address, pass the position words through, pass up to
// MAX_DEG neighbours through (dropping the rest), then emit an END word
// carrying the forwarded neighbour count.
module fetch_scheduler
    import fetch_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DIM          = 2,
    parameter int MAX_DEG      = 64,
    parameter int QUIET_CYCLES = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    input  logic [NUM_REQ*32-1:0]      req_addr_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    output logic [31:0]                fetch_addr_out,
    output logic                       fetch_valid_out,
    input  logic                       fetch_ready_in,
    input  logic [31:0]                pos_data_in,
    input  logic                       pos_valid_in,
    output logic                       pos_deq_out,
    input  logic [31:0]                neigh_data_in,
    input  logic                       neigh_valid_in,
    output logic                       neigh_deq_out,
    output logic [31:0]                resp_data_out,
    output logic [1:0]                 resp_kind_out,
    output logic [$clog2(NUM_REQ)-1:0] resp_id_out,
    output logic                       resp_valid_out,
    input  logic                       resp_ready_in,
    output logic                       busy_out
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(DIM + 1);
    localparam int NW = $clog2(MAX_DEG + 1);
    localparam int QW = $clog2(QUIET_CYCLES + 1);

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_id;
    logic [31:0]   r_addr;
    logic [PW-1:0] r_pos_cnt;
    logic [NW-1:0] r_nb_cnt;
    logic [QW-1:0] r_quiet;

    logic [NUM_REQ-1:0][31:0] w_addr_arr;
    logic [NUM_REQ-1:0]       w_req_ok;
    logic [NUM_REQ-1:0]       w_gnt;
    logic [IW-1:0]            w_idx;
    logic                     w_any;
    logic                     w_idle;
    logic                     w_nb_room;
    logic                     w_pos_deq;
    logic                     w_neigh_deq;
    logic                     w_resp_valid;
    resp_t                    w_resp;

    assign w_addr_arr = req_addr_in;
    assign w_idle     = (r_state == ST_IDLE);
    // Grants are only offered while idle and the fetch unit can take work.
    assign w_req_ok   = (w_idle && fetch_ready_in) ? req_valid_in : '0;
    assign w_nb_room  = (r_nb_cnt < NW'(MAX_DEG));

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req   (w_req_ok),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Response mux: FIFO heads pass straight through, END carries the count.
    always_comb begin
        w_resp       = '0;
        w_resp_valid = 1'b0;
        w_pos_deq    = 1'b0;
        w_neigh_deq  = 1'b0;
        if (!w_idle) w_resp.id = ID_W_MAX'(r_id);
        case (r_state)
            ST_DRAIN_POS: begin
                w_resp.kind  = KIND_POS;
                w_resp.data  = pos_data_in;
                w_resp_valid = pos_valid_in;
                w_pos_deq    = pos_valid_in & resp_ready_in;
            end
            ST_DRAIN_NEIGH: begin
                w_resp.kind  = KIND_NEIGH;
                w_resp.data  = neigh_data_in;
                w_resp_valid = neigh_valid_in & w_nb_room;
                // Past the cap, words are popped without being forwarded.
                w_neigh_deq  = neigh_valid_in & (resp_ready_in | ~w_nb_room);
            end
            ST_END: begin
                w_resp.kind  = KIND_END;
                w_resp.data  = 32'(r_nb_cnt);
                w_resp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign req_ready_out   = w_gnt;
    assign fetch_addr_out  = r_addr;
    assign fetch_valid_out = (r_state == ST_ISSUE);
    assign pos_deq_out     = w_pos_deq;
    assign neigh_deq_out   = w_neigh_deq;
    assign resp_data_out   = w_resp.data;
    assign resp_kind_out   = w_resp.kind;
    assign resp_id_out     = IW'(w_resp.id);
    assign resp_valid_out  = w_resp_valid;
    assign busy_out        = !w_idle;

    // Scheduler FSM, RR pointer and per-fetch counters (all saturating).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_id      <= '0;
            r_addr    <= '0;
            r_pos_cnt <= '0;
            r_nb_cnt  <= '0;
            r_quiet   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_addr  <= w_addr_arr[w_idx];
                        r_id    <= w_idx;
                        r_ptr   <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_pos_cnt <= '0;
                    r_nb_cnt  <= '0;
                    r_quiet   <= '0;
                    r_state   <= ST_DRAIN_POS;
                end
                ST_DRAIN_POS: begin
                    if (w_pos_deq) begin
                        if (r_pos_cnt != PW'(DIM)) r_pos_cnt <= r_pos_cnt + PW'(1);
                        if (r_pos_cnt == PW'(DIM - 1)) r_state <= ST_DRAIN_NEIGH;
                    end
                end
                ST_DRAIN_NEIGH: begin
                    if (neigh_valid_in) begin
                        r_quiet <= '0;
                        if (w_nb_room && resp_ready_in) r_nb_cnt <= r_nb_cnt + NW'(1);
                    end else begin
                        if (r_quiet != QW'(QUIET_CYCLES)) r_quiet <= r_quiet + QW'(1);
                        if (r_quiet == QW'(QUIET_CYCLES - 1)) r_state <= ST_END;
                    end
                end
                ST_END: begin
                    if (resp_ready_in) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_scheduler.sv
// Bench for fetch_scheduler: a behavioural fetch unit with position and
// neighbour FIFOs, a scoreboard filled at grant time, a table of arbitration
// vectors and hand-written multi-cycle sequences.
module tb_fetch_scheduler;
    localparam int NR   = 4;
    localparam int DIM  = 2;
    localparam int MAXD = 2;
    localparam int QC   = 4;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic [NR-1:0]     req_valid_in = '0;
    logic [NR*32-1:0]  req_addr_in = '0;
    logic [NR-1:0]     req_ready_out;
    logic [31:0]       fetch_addr_out;
    logic              fetch_valid_out;
    logic              fetch_ready_in = 1'b1;
    logic [31:0]       pos_data_in = '0;
    logic              pos_valid_in = 1'b0;
    logic              pos_deq_out;
    logic [31:0]       neigh_data_in = '0;
    logic              neigh_valid_in = 1'b0;
    logic              neigh_deq_out;
    logic [31:0]       resp_data_out;
    logic [1:0]        resp_kind_out;
    logic [1:0]        resp_id_out;
    logic              resp_valid_out;
    logic              resp_ready_in = 1'b1;
    logic              busy_out;

    fetch_scheduler #(.NUM_REQ(NR), .DIM(DIM), .MAX_DEG(MAXD), .QUIET_CYCLES(QC)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_addr_in(req_addr_in), .req_ready_out(req_ready_out),
        .fetch_addr_out(fetch_addr_out), .fetch_valid_out(fetch_valid_out), .fetch_ready_in(fetch_ready_in),
        .pos_data_in(pos_data_in), .pos_valid_in(pos_valid_in), .pos_deq_out(pos_deq_out),
        .neigh_data_in(neigh_data_in), .neigh_valid_in(neigh_valid_in), .neigh_deq_out(neigh_deq_out),
        .resp_data_out(resp_data_out), .resp_kind_out(resp_kind_out), .resp_id_out(resp_id_out),
        .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  k;
        logic [1:0]  id;
    } rsp_t;

    typedef struct {
        logic [NR-1:0] req;
        logic          frdy;
        logic [NR-1:0] exp_rdy;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Vertex memory seen by the fetch unit.
    function automatic int vdeg(input logic [31:0] a);
        case (a)
            32'h10:  return 2;
            32'h20:  return 5;
            32'h30:  return 0;
            32'h40:  return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] vpos(input logic [31:0] a, input int i);
        if (a == 32'h10) return (i == 0) ? 32'd5 : 32'd7;
        return a * 4 + 32'(i) + 32'd1;
    endfunction

    function automatic logic [31:0] vnb(input logic [31:0] a, input int i);
        if (a == 32'h10) return (i == 0) ? 32'd3 : 32'd9;
        return a + 32'h100 + 32'(i);
    endfunction

    // Fetch-unit model: samples handshakes at negedge, updates FIFOs after posedge.
    logic [31:0] pq[$];
    logic [31:0] nq[$];
    logic        s_fv = 1'b0, s_pd = 1'b0, s_nd = 1'b0, s_rst = 1'b0;
    logic [31:0] s_fa = '0;
    int          cyc = 0;
    logic        bp_en = 1'b0;

    always @(negedge clk_in) begin
        s_fv  = fetch_valid_out;
        s_fa  = fetch_addr_out;
        s_pd  = pos_deq_out;
        s_nd  = neigh_deq_out;
        s_rst = rst_in;
    end

    always @(posedge clk_in) begin
        #1;
        if (s_rst) begin
            pq.delete();
            nq.delete();
        end else begin
            if (s_pd && pq.size() > 0) void'(pq.pop_front());
            if (s_nd && nq.size() > 0) void'(nq.pop_front());
            if (s_fv) begin
                chk("stray_words", 64'(pq.size() + nq.size()), 0);
                for (int i = 0; i < DIM; i++) pq.push_back(vpos(s_fa, i));
                for (int i = 0; i < vdeg(s_fa); i++) nq.push_back(vnb(s_fa, i));
            end
        end
        pos_valid_in   = (pq.size() > 0);
        pos_data_in    = (pq.size() > 0) ? pq[0] : 32'd0;
        neigh_valid_in = (nq.size() > 0);
        neigh_data_in  = (nq.size() > 0) ? nq[0] : 32'd0;
    end

    // Consumer: ready always, or 1-in-3 when back-pressure is enabled.
    always @(posedge clk_in) begin
        cyc++;
        #1;
        resp_ready_in = bp_en ? (cyc % 3 == 0) : 1'b1;
    end

    // Monitor: grants fill the scoreboard, responses drain it.
    rsp_t        sb[$];
    logic [31:0] fa_q[$];
    int          eg_q[$];
    int          g_cnt = 0, f_cnt = 0;
    int          last_pos_cyc = 0, end_cyc = 0;
    logic        p_stall = 1'b0, p_fv = 1'b0, p_endv = 1'b0;
    rsp_t        p_rsp, cur;
    int          g, nfw;
    logic [31:0] ga;

    always @(negedge clk_in) begin
        cur = '{d: resp_data_out, k: resp_kind_out, id: resp_id_out};
        if (rst_in) begin
            sb.delete();
            fa_q.delete();
            p_stall = 1'b0;
            p_fv    = 1'b0;
            p_endv  = 1'b0;
        end else begin
            if ((req_valid_in & req_ready_out) != '0) begin
                g_cnt++;
                chk("grant_onehot", 64'($onehot(req_ready_out)), 1);
                chk("no_overlap", 64'(sb.size()), 0);
                g = 0;
                for (int i = NR - 1; i >= 0; i--) if (req_ready_out[i]) g = i;
                if (eg_q.size() > 0) chk("grant_order", 64'(g), 64'(eg_q.pop_front()));
                ga = req_addr_in[g*32 +: 32];
                fa_q.push_back(ga);
                for (int i = 0; i < DIM; i++) sb.push_back('{d: vpos(ga, i), k: 2'd0, id: 2'(g)});
                nfw = (vdeg(ga) < MAXD) ? vdeg(ga) : MAXD;
                for (int i = 0; i < nfw; i++) sb.push_back('{d: vnb(ga, i), k: 2'd1, id: 2'(g)});
                sb.push_back('{d: 32'(nfw), k: 2'd2, id: 2'(g)});
            end
            if (fetch_valid_out) begin
                f_cnt++;
                chk("fetch_single_pulse", 64'(p_fv), 0);
                chk("fetch_addr", 64'(fetch_addr_out), (fa_q.size() > 0) ? 64'(fa_q.pop_front()) : 64'hDEAD);
            end
            p_fv = fetch_valid_out;
            if (p_stall) chk("stall_stable", {resp_valid_out, cur}, {1'b1, p_rsp});
            p_stall = resp_valid_out & !resp_ready_in;
            p_rsp   = cur;
            if (resp_valid_out && resp_ready_in) begin
                if (sb.size() == 0) chk("resp_unexpected", 64'(sb.size()), 1);
                else chk("resp", 64'(cur), 64'(sb.pop_front()));
                if (resp_kind_out == 2'd0) last_pos_cyc = cyc;
                if (resp_kind_out == 2'd2) chk("neigh_empty_at_end", 64'(nq.size()), 0);
            end
            if (resp_valid_out && resp_kind_out == 2'd2 && !p_endv) end_cyc = cyc;
            p_endv = resp_valid_out && (resp_kind_out == 2'd2);
        end
    end

    task automatic do_req(input int id, input logic [31:0] addr);
        int start, n;
        @(posedge clk_in); #2;
        req_addr_in[id*32 +: 32] = addr;
        req_valid_in[id] = 1'b1;
        start = g_cnt;
        n = 0;
        while (g_cnt == start && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        chk("granted", 64'(g_cnt != start), 1);
        @(posedge clk_in); #2;
        req_valid_in[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!(busy_out == 1'b0 && sb.size() == 0) && n < 500);
        chk("reach_idle", 64'(busy_out == 1'b0 && sb.size() == 0), 1);
    endtask

    task automatic do_reset();
        @(posedge clk_in); #2 rst_in = 1'b1;
        @(posedge clk_in); #2 rst_in = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk(nm, {req_ready_out, fetch_addr_out, fetch_valid_out, pos_deq_out, neigh_deq_out,
                 resp_data_out, resp_kind_out, resp_id_out, resp_valid_out, busy_out}, 0);
    endtask

    vec_t vecs[7];

    initial begin
        int f0, n;
        vecs[0] = '{req: 4'b0000, frdy: 1'b1, exp_rdy: 4'b0000};
        vecs[1] = '{req: 4'b0001, frdy: 1'b1, exp_rdy: 4'b0001};
        vecs[2] = '{req: 4'b1010, frdy: 1'b1, exp_rdy: 4'b0010};
        vecs[3] = '{req: 4'b1000, frdy: 1'b1, exp_rdy: 4'b1000};
        vecs[4] = '{req: 4'b1111, frdy: 1'b0, exp_rdy: 4'b0000};
        vecs[5] = '{req: 4'b1100, frdy: 1'b1, exp_rdy: 4'b0100};
        vecs[6] = '{req: 4'b0110, frdy: 1'b1, exp_rdy: 4'b0010};

        repeat (3) @(posedge clk_in);
        #2 rst_in = 1'b0;
        #1 chk_outputs_zero("reset_outputs");

        // Arbitration vectors, pointer at 0; withdrawn before any edge.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk_in); #2;
            req_valid_in   = vecs[i].req;
            fetch_ready_in = vecs[i].frdy;
            #1 chk($sformatf("vec%0d_ready", i), 64'(req_ready_out), 64'(vecs[i].exp_rdy));
            #1 req_valid_in = '0;
            fetch_ready_in = 1'b1;
        end

        // Single request: POS 5, POS 7, NEIGH 3, NEIGH 9, END 2.
        f0 = f_cnt;
        do_req(0, 32'h10);
        wait_idle();
        chk("single_fetch_count", 64'(f_cnt - f0), 1);

        // Contention from reset: requesters 0, 1, 3 held valid.
        do_reset();
        eg_q = '{0, 1, 3, 0, 1, 3};
        f0 = g_cnt;
        @(posedge clk_in); #2;
        req_addr_in[0*32 +: 32] = 32'h40;
        req_addr_in[1*32 +: 32] = 32'h10;
        req_addr_in[3*32 +: 32] = 32'h30;
        req_valid_in = 4'b1011;
        n = 0;
        while (g_cnt < f0 + 6 && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        @(posedge clk_in); #2 req_valid_in = '0;
        wait_idle();
        chk("contention_grants", 64'(g_cnt - f0), 6);
        chk("contention_order_done", 64'(eg_q.size()), 0);

        // Back-pressure on a plain and a capped vertex.
        bp_en = 1'b1;
        do_req(2, 32'h10);
        wait_idle();
        do_req(2, 32'h20);
        wait_idle();
        @(posedge clk_in); #2 bp_en = 1'b0;

        // Degree cap, then a clean follow-up fetch.
        do_req(1, 32'h20);
        wait_idle();
        do_req(1, 32'h10);
        wait_idle();

        // Zero-degree vertex: END 0 after QC empty cycles.
        do_req(3, 32'h30);
        wait_idle();
        chk("quiet_gap", 64'(end_cyc - last_pos_cyc), 64'(QC + 1));

        // Reset mid-neighbour drain (pointer is 1 before the reset).
        do_req(0, 32'h20);
        n = 0;
        do begin
            @(posedge clk_in); #2;
            n++;
        end while (!(resp_valid_out && resp_kind_out == 2'd1) && n < 200);
        chk("reached_drain_neigh", 64'(resp_valid_out && resp_kind_out == 2'd1), 1);
        rst_in = 1'b1;
        @(posedge clk_in); #2 rst_in = 1'b0;
        #1 chk_outputs_zero("midreset_outputs");
        @(posedge clk_in); #2 req_valid_in = 4'b0101;
        #1 chk("midreset_ptr_zero", 64'(req_ready_out), 64'(4'b0001));
        #1 req_valid_in = '0;
        do_req(2, 32'h10);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_scheduler.md
Name: fetch_scheduler

Overview:
Round-robin scheduler that shares one graph_fetch vertex-fetch unit between NUM_REQ requesters (e.g. force-calculation lanes). It accepts a vertex address from one requester and issues it to the fetch unit. It then drains the position FIFO and the neighbour FIFO into a single tagged response stream routed to that requester. Only one fetch is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DIM, 2, position words per vertex
MAX_DEG, 64, maximum neighbours forwarded per vertex; excess neighbours are dequeued and dropped
QUIET_CYCLES, 4, consecutive cycles with the neighbour FIFO empty that end a neighbour list

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
req_valid_in  in  NUM_REQ  per-requester fetch request
req_addr_in  in  NUM_REQ*32  packed vertex addresses, requester i at [32i+31:32i]
req_ready_out  out  NUM_REQ  one-hot grant; a request is accepted when valid&ready
fetch_addr_out  out  32  vertex address to the fetch unit
fetch_valid_out  out  1  single-cycle issue pulse
fetch_ready_in  in  1  fetch unit idle
pos_data_in  in  32  position FIFO head
pos_valid_in  in  1  position FIFO head valid
pos_deq_out  out  1  position FIFO dequeue
neigh_data_in  in  32  neighbour FIFO head
neigh_valid_in  in  1  neighbour FIFO head valid
neigh_deq_out  out  1  neighbour FIFO dequeue
resp_data_out  out  32  response word
resp_kind_out  out  2  0 = POS, 1 = NEIGH, 2 = END
resp_id_out  out  $clog2(NUM_REQ)  owning requester
resp_valid_out  out  1  response valid
resp_ready_in  in  1  consumer accepts the response
busy_out  out  1  state != IDLE

Behaviour:
- Reset: the clock and reset are one clock, synchronous active-high, named clk_in/rst_in. At reset, state = IDLE, RR pointer = 0, and all outputs = 0. A reset mid-operation abandons the fetch without draining. The fetch unit is reset by the same rst_in.
- FSM states: IDLE, ISSUE, DRAIN_POS, DRAIN_NEIGH, END.
- IDLE:
  - Grant goes to the first valid requester at or after the RR pointer, wrapping modulo NUM_REQ.
  - req_ready_out is combinational and one-hot, and only asserted in IDLE while fetch_ready_in=1.
  - On accept: latch the address and id, set RR pointer = id+1 (wrap), and go to ISSUE.
  - If no request is valid, the pointer is unchanged.
- ISSUE: fetch_valid_out=1 for exactly one cycle with the latched address. Clear the position counter, neighbour counter and quiet counter, then go to DRAIN_POS.
- DRAIN_POS:
  - resp_valid_out = pos_valid_in, kind POS, data pos_data_in (combinational pass-through, zero latency).
  - pos_deq_out = pos_valid_in & resp_ready_in.
  - After DIM dequeues, go to DRAIN_NEIGH.
  - Neighbour FIFO is not dequeued in this state; it back-pressures the fetch unit.
- DRAIN_NEIGH:
  - If neigh_valid_in: neigh_deq_out = resp_ready_in, or =1 when neighbour count >= MAX_DEG (drop). resp_valid_out = neigh_valid_in & (count < MAX_DEG), kind NEIGH. Count increments only on forwarded words. Quiet counter clears.
  - If !neigh_valid_in: quiet counter increments. On reaching QUIET_CYCLES, go to END.
  - A stalled response (valid & !ready) does not advance the quiet counter.
- END:
  - resp_valid_out=1, kind END, data = forwarded neighbour count (zero-extended). Held until resp_ready_in, then go to IDLE.
  - Stray position or neighbour words arriving after END are not dequeued and stay for the next fetch. Such words are a protocol error, flagged by a bench assertion.
- Response stability: resp_* is held stable while valid & !ready, except in pass-through states, where the source FIFO head is itself stable until dequeued.
- resp_id_out = latched id in every non-IDLE state.
- Widths: counters are $clog2(MAX_DEG+1) and $clog2(QUIET_CYCLES+1) bits and saturate; they never wrap.
- Simultaneous events: a request arriving in a non-IDLE state waits with ready=0 and no starvation; RR guarantees service within NUM_REQ fetches.

Decomposition:
- Package fetch_sched_pkg: state enum, resp_kind enum (KIND_POS, KIND_NEIGH, KIND_END), and a response struct {data, kind, id}.
- Sub-module rr_arbiter (parameter N): request vector plus pointer in, one-hot grant and encoded index out, purely combinational. The pointer register stays in fetch_scheduler.

Test Plan:
- Single request: req 0 at addr 0x10, memory has pos {5, 7} and neighbours {3, 9, 0} -> responses POS 5, POS 7, NEIGH 3, NEIGH 9, END 2, all with id 0; fetch_valid_out pulses once with 0x10.
- Contention: requesters 0, 1 and 3 all valid continuously from reset -> grant order 0, 1, 3, 0, 1, 3; exactly one grant per fetch; no overlap.
- Back-pressure: resp_ready_in toggled with 1-in-3 duty -> identical word sequence; no dropped or duplicated words; resp_data stable while stalled.
- Degree cap: MAX_DEG=2 with a vertex of 5 neighbours -> NEIGH x2, then END 2; neighbour FIFO empty before END; the next fetch sees no stale words.
- Zero-degree vertex: neighbour list {0} -> POS x DIM, then END 0 after QUIET_CYCLES idle cycles.
- Reset mid-DRAIN_NEIGH: assert rst_in for 1 cycle -> next cycle busy_out=0, all outputs 0, RR pointer 0; a new request on requester 2 completes normally.
